// File: rtl/ripple_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : ripple_adder_seq
// Purpose  : Word-serial wide adder. A WORDS*DATA_WIDTH-bit add request is
//            processed one DATA_WIDTH slice per cycle through a single shared
//            adder, with the inter-slice carry held in a register.
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous active-high reset
//            in_a     - operand A (W bits), sampled on accept
//            in_b     - operand B (W bits), sampled on accept
//            in_ci    - carry-in, sampled on accept
//            in_vld   - request valid
//            in_rd    - ready to accept (IDLE and not in reset)
//            out_s    - registered sum mod 2^W
//            out_co   - registered final carry-out
//            out_vld  - result valid
//            out_rd   - consumer ready
//            busy     - operation in progress or result pending
// Revision : 1.0 - initial release
// ============================================================================
module ripple_adder_seq #(
    parameter int DATA_WIDTH = 4,
    parameter int WORDS      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH*WORDS-1:0] in_a,
    input  logic [DATA_WIDTH*WORDS-1:0] in_b,
    input  logic                        in_ci,
    input  logic                        in_vld,
    output logic                        in_rd,
    output logic [DATA_WIDTH*WORDS-1:0] out_s,
    output logic                        out_co,
    output logic                        out_vld,
    input  logic                        out_rd,
    output logic                        busy
);

    localparam int c_W     = DATA_WIDTH * WORDS;
    localparam int c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_carry;
    logic [c_W-1:0]        r_a;
    logic [c_W-1:0]        r_b;

    logic [DATA_WIDTH-1:0] w_a_slice;
    logic [DATA_WIDTH-1:0] w_b_slice;
    logic [DATA_WIDTH:0]   w_sum_ext;
    logic                  w_last;

    // Slice selection is a decoded mux over constant part-selects, so the
    // index never produces an out-of-range select even for odd WORDS.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_a_slice = r_a[k*DATA_WIDTH +: DATA_WIDTH];
                w_b_slice = r_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The shared slice adder: one extra bit carries out to the next slice.
    assign w_sum_ext = {1'b0, w_a_slice} + {1'b0, w_b_slice}
                     + {{DATA_WIDTH{1'b0}}, r_carry};
    assign w_last    = (r_idx == c_IDX_LAST);

    assign in_rd = (r_state == c_IDLE) && !rst;
    assign busy  = (r_state == c_RUN) || (r_state == c_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            out_s   <= '0;
            out_co  <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_vld) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_ci;
                        r_idx   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_idx == c_IDX_W'(k)) begin
                            out_s[k*DATA_WIDTH +: DATA_WIDTH] <= w_sum_ext[DATA_WIDTH-1:0];
                        end
                    end
                    r_carry <= w_sum_ext[DATA_WIDTH];
                    if (w_last) begin
                        // Index returns to zero instead of stepping past the
                        // last slice, keeping it within 0..WORDS-1.
                        out_co  <= w_sum_ext[DATA_WIDTH];
                        out_vld <= 1'b1;
                        r_idx   <= '0;
                        r_state <= c_DONE;
                    end else begin
                        r_idx   <= r_idx + c_IDX_ONE;
                    end
                end
                c_DONE: begin
                    if (out_rd) begin
                        out_vld <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
